// File: rtl/sram_controller_pkg.sv
// Shared widths, address-map defaults and FSM encodings for the SRAM controller.
package sram_controller_pkg;

   localparam int unsigned WORD_WIDTH      = 32;
   localparam int unsigned SRAM_DATA_WIDTH = 16;
   localparam int unsigned SRAM_ADDR_BITS  = 18;
   localparam int unsigned SRAM_ADDR_BASE  = 1024;
   localparam int unsigned STATE_WIDTH     = 3;

   typedef enum logic [STATE_WIDTH-1:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } state_t;

   function automatic logic is_access_state(input state_t s);
      return (s == RD_LO) || (s == RD_HI) || (s == WR_LO) || (s == WR_HI);
   endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait-state counter: cleared on state entry, saturates at WAIT_CYCLES-1.
module sram_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic phase_last,
   output logic phase_pre_last
);

   localparam int unsigned CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int unsigned LAST     = WAIT_CYCLES - 1;
   localparam int unsigned PRE_LAST = (WAIT_CYCLES >= 2) ? WAIT_CYCLES - 2 : 0;
   localparam logic        HAS_PRE  = (WAIT_CYCLES >= 2);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (!phase_last)
         cnt <= cnt + CNT_W'(1);
   end

   assign phase_last     = (cnt == CNT_W'(LAST));
   // Next cycle will be the last of the phase (only meaningful for WAIT_CYCLES >= 2)
   assign phase_pre_last = HAS_PRE && (cnt == CNT_W'(PRE_LAST));

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit memory-stage requests into two 16-bit async-SRAM accesses with wait states,
// holding the pipeline via ready until the access completes.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES     = 3,
   parameter int unsigned ADDR_BASE       = SRAM_ADDR_BASE,
   parameter int unsigned SRAM_ADDR_WIDTH = SRAM_ADDR_BITS
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [WORD_WIDTH-1:0]      address,
   input  logic [WORD_WIDTH-1:0]      wdata,
   output logic [WORD_WIDTH-1:0]      rdata,
   output logic                       ready,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
   output logic                       sram_dq_oe,
   input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
   output logic                       sram_we_n
);

   localparam int unsigned IDX_W = SRAM_ADDR_WIDTH - 1;
   localparam logic        SINGLE_CYCLE_PHASE = (WAIT_CYCLES == 1);

   state_t                     state, state_next;
   logic                       phase_enter;
   logic                       phase_last, phase_pre_last;
   logic [IDX_W-1:0]           idx_in, idx_q, idx_next;
   logic [SRAM_DATA_WIDTH-1:0] wdata_hi_q, wdata_hi_next;
   logic [WORD_WIDTH-1:0]      rdata_next;
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr_next;
   logic [SRAM_DATA_WIDTH-1:0] sram_dq_out_next;
   logic                       sram_dq_oe_next, sram_we_n_next;

   // Word index relative to the SRAM window; subtraction wraps, result truncated
   assign idx_in = IDX_W'((address - WORD_WIDTH'(ADDR_BASE)) >> 2);

   assign phase_enter = (state_next != state);

   sram_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait (
      .clk            (clk),
      .rst            (rst),
      .clear          (phase_enter),
      .phase_last     (phase_last),
      .phase_pre_last (phase_pre_last)
   );

   assign ready = rst || (state == DONE) || ((state == IDLE) && !mem_read && !mem_write);

   // Next state plus the SRAM-side values for the state about to be entered
   always_comb begin
      state_next       = state;
      idx_next         = idx_q;
      wdata_hi_next    = wdata_hi_q;
      rdata_next       = rdata;
      sram_addr_next   = sram_addr;
      sram_dq_out_next = sram_dq_out;
      sram_dq_oe_next  = 1'b0;
      sram_we_n_next   = 1'b1;

      case (state)
         IDLE: begin
            if (mem_write) begin
               state_next    = WR_LO;
               idx_next      = idx_in;
               wdata_hi_next = wdata[WORD_WIDTH-1:SRAM_DATA_WIDTH];
            end else if (mem_read) begin
               state_next = RD_LO;
               idx_next   = idx_in;
            end
         end
         RD_LO: if (phase_last) begin
            rdata_next[SRAM_DATA_WIDTH-1:0] = sram_dq_in;
            state_next = RD_HI;
         end
         RD_HI: if (phase_last) begin
            rdata_next[WORD_WIDTH-1:SRAM_DATA_WIDTH] = sram_dq_in;
            state_next = DONE;
         end
         WR_LO:   if (phase_last) state_next = WR_HI;
         WR_HI:   if (phase_last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // WE rises on the final cycle of each write phase so data holds past the edge
      case (state_next)
         RD_LO: sram_addr_next = {idx_next, 1'b0};
         RD_HI: sram_addr_next = {idx_next, 1'b1};
         WR_LO: begin
            sram_addr_next  = {idx_next, 1'b0};
            sram_dq_oe_next = 1'b1;
            sram_we_n_next  = phase_enter ? SINGLE_CYCLE_PHASE : phase_pre_last;
            if (phase_enter)
               sram_dq_out_next = wdata[SRAM_DATA_WIDTH-1:0];
         end
         WR_HI: begin
            sram_addr_next   = {idx_next, 1'b1};
            sram_dq_oe_next  = 1'b1;
            sram_we_n_next   = phase_enter ? SINGLE_CYCLE_PHASE : phase_pre_last;
            sram_dq_out_next = wdata_hi_next;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx_q       <= '0;
         wdata_hi_q  <= '0;
         rdata       <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         state       <= state_next;
         idx_q       <= idx_next;
         wdata_hi_q  <= wdata_hi_next;
         rdata       <= rdata_next;
         sram_addr   <= sram_addr_next;
         sram_dq_out <= sram_dq_out_next;
         sram_dq_oe  <= sram_dq_oe_next;
         sram_we_n   <= sram_we_n_next;
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: WAIT_CYCLES=3 instance under the monitor,
// plus a WAIT_CYCLES=1 instance checked inline.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;

   logic        mem_read, mem_write;
   logic [31:0] address, wdata, rdata;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   logic        mem_read1, mem_write1;
   logic [31:0] address1, wdata1, rdata1;
   logic        ready1;
   logic [17:0] sram_addr1;
   logic [15:0] sram_dq_out1, sram_dq_in1;
   logic        sram_dq_oe1, sram_we_n1;

   logic [15:0] mem  [0:63];
   logic [15:0] mem1 [0:63];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(3), .ADDR_BASE(1024), .SRAM_ADDR_WIDTH(18)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   sram_controller #(.WAIT_CYCLES(1), .ADDR_BASE(1024), .SRAM_ADDR_WIDTH(18)) dut1 (
      .clk(clk), .rst(rst), .mem_read(mem_read1), .mem_write(mem_write1),
      .address(address1), .wdata(wdata1), .rdata(rdata1), .ready(ready1),
      .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
      .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
   );

   // Async SRAM models: array written on any cycle WE is low while the bus is driven
   assign sram_dq_in  = mem[sram_addr[5:0]];
   assign sram_dq_in1 = mem1[sram_addr1[5:0]];

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]  = 16'hA000 + 16'(i);
         mem1[i] = 16'hA000 + 16'(i);
      end
      mem[4]  = 16'h5678; mem[5]  = 16'h1234;
      mem1[4] = 16'h5678; mem1[5] = 16'h1234;
      forever begin
         @(negedge clk);
         if (!sram_we_n && sram_dq_oe)   mem[sram_addr[5:0]]   = sram_dq_out;
         if (!sram_we_n1 && sram_dq_oe1) mem1[sram_addr1[5:0]] = sram_dq_out1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      int          busy;
      int          we_low;
      int          oe_cyc;
      logic [17:0] lo;
      int          gap;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   bit   have_cur = 0;
   bit   in_busy  = 0;
   int   busy, we_low, oe_c, nlo, nhi, gap_seen;
   int   hi_run   = 0;
   int   done_cnt = 0;

   function automatic void push(input logic [31:0] rd, input int b, input int we,
                                input int oe, input logic [17:0] lo, input int gap);
      exp_t e;
      e.rdata = rd; e.busy = b; e.we_low = we; e.oe_cyc = oe; e.lo = lo; e.gap = gap;
      sb.push_back(e);
   endfunction

   // Monitor: a ready-low run is one transaction, judged on the DONE cycle
   always @(negedge clk) begin
      if (rst) begin
         in_busy  = 0;
         have_cur = 0;
         hi_run   = 0;
      end else if (!ready) begin
         if (!in_busy) begin
            in_busy = 1; busy = 0; we_low = 0; oe_c = 0; nlo = 0; nhi = 0;
            gap_seen = hi_run;
            if (sb.size() == 0) begin
               have_cur = 0;
               n_cmp++; n_bad++;
               $display("FAIL unexpected_request: got busy with empty scoreboard at %0t", $time);
            end else begin
               cur = sb.pop_front();
               have_cur = 1;
            end
         end else if (have_cur) begin
            if (sram_addr == cur.lo)            nlo++;
            if (sram_addr == 18'(cur.lo + 18'd1)) nhi++;
         end
         busy++;
         we_low += int'(!sram_we_n);
         oe_c   += int'(sram_dq_oe);
         hi_run = 0;
      end else begin
         if (in_busy) begin
            if (have_cur) begin
               chk("rdata",          rdata,  cur.rdata);
               chk("busy_cycles",    busy,   cur.busy);
               chk("we_low_cycles",  we_low, cur.we_low);
               chk("oe_cycles",      oe_c,   cur.oe_cyc);
               chk("addr_lo_cycles", nlo,    3);
               chk("addr_hi_cycles", nhi,    3);
               if (cur.gap >= 0) chk("ready_gap", gap_seen, cur.gap);
            end
            done_cnt++;
            in_busy = 0;
         end
         hi_run++;
      end
   end

   task automatic req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
      mem_write = wr; mem_read = rd; address = a; wdata = d;
   endtask

   // Returns at posedge+1 of the IDLE cycle following DONE
   task automatic wait_done(input int prev);
      for (int k = 0; k < 100 && done_cnt == prev; k++) @(posedge clk);
      if (done_cnt == prev) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout: got no completion after 100 cycles, expected one");
      end
      #1;
   endtask

   task automatic run1(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input int exp_busy,
                       input int exp_we, input int exp_oe);
      int  b = 0, we = 0, oe = 0;
      bit  done = 0;
      mem_write1 = wr; mem_read1 = !wr; address1 = a; wdata1 = d;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ready1) begin done = 1; break; end
         b++;
         we += int'(!sram_we_n1);
         oe += int'(sram_dq_oe1);
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL w1_timeout: got no completion after 50 cycles, expected one");
      end else begin
         chk("w1_rdata",  rdata1, exp_rdata);
         chk("w1_busy",   b,  exp_busy);
         chk("w1_we_low", we, exp_we);
         chk("w1_oe",     oe, exp_oe);
      end
      @(posedge clk); #1;
      mem_write1 = 1'b0; mem_read1 = 1'b0;
   endtask

   initial begin
      int p;
      rst = 1'b1;
      req(0, 0, 32'h0, 32'h0);
      mem_read1 = 1'b0; mem_write1 = 1'b0; address1 = '0; wdata1 = '0;

      // Reset state, and ready held high even with a request pulsed
      repeat (2) @(posedge clk); #1;
      chk("rst_rdata",   rdata,       32'h0);
      chk("rst_addr",    sram_addr,   32'h0);
      chk("rst_dq_out",  sram_dq_out, 32'h0);
      chk("rst_dq_oe",   sram_dq_oe,  32'h0);
      chk("rst_we_n",    sram_we_n,   32'h1);
      chk("rst_ready",   ready,       32'h1);
      mem_read = 1'b1; #1;
      chk("rst_ready_req", ready, 32'h1);
      @(posedge clk); #1;
      chk("rst_ready_req2", ready, 32'h1);
      mem_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Read word at 1032 -> SRAM 4/5
      push(32'h12345678, 7, 0, 0, 18'd4, -1);
      p = done_cnt; req(0, 1, 32'd1032, 32'h0); wait_done(p); req(0, 0, 32'h0, 32'h0);

      // Write 0xDEADBEEF at 1028 -> SRAM 2/3, rdata untouched
      repeat (2) @(posedge clk); #1;
      push(32'h12345678, 7, 4, 6, 18'd2, -1);
      p = done_cnt; req(1, 0, 32'd1028, 32'hDEADBEEF); wait_done(p); req(0, 0, 32'h0, 32'h0);
      chk("mem2", mem[2], 32'hBEEF);
      chk("mem3", mem[3], 32'hDEAD);

      // Both asserted: write wins, then the held read, then a held write
      repeat (2) @(posedge clk); #1;
      push(32'h12345678, 7, 4, 6, 18'd8, -1);
      push(32'hCAFEF00D, 7, 0, 0, 18'd8, 1);
      p = done_cnt; req(1, 1, 32'd1040, 32'hCAFEF00D); wait_done(p);
      req(0, 1, 32'd1040, 32'h0); wait_done(p + 1);
      push(32'hCAFEF00D, 7, 4, 6, 18'd10, 1);
      req(1, 0, 32'd1044, 32'h0BADF00D); wait_done(p + 2);
      req(0, 0, 32'h0, 32'h0);
      chk("mem10", mem[10], 32'hF00D);
      chk("mem11", mem[11], 32'h0BAD);

      // Reset in the second cycle of WR_HI on a write to 1036 -> SRAM 6/7
      repeat (2) @(posedge clk); #1;
      push(32'h0, 0, 0, 0, 18'd6, -1);
      req(1, 0, 32'd1036, 32'h11112222);
      repeat (5) @(posedge clk); #1;
      rst = 1'b1; #1;
      chk("abort_we_n",   sram_we_n,  32'h1);
      chk("abort_dq_oe",  sram_dq_oe, 32'h0);
      chk("abort_addr",   sram_addr,  32'h0);
      chk("abort_ready",  ready,      32'h1);
      mem_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; #1;
      chk("abort_idle_ready", ready, 32'h1);
      chk("mem6", mem[6], 32'h2222);
      chk("mem7", mem[7], 32'h1111);
      repeat (2) @(posedge clk); #1;
      push(32'h11112222, 7, 0, 0, 18'd6, -1);
      p = done_cnt; req(0, 1, 32'd1036, 32'h0); wait_done(p); req(0, 0, 32'h0, 32'h0);

      // WAIT_CYCLES=1: three busy cycles, WE never asserted
      repeat (2) @(posedge clk); #1;
      run1(0, 32'd1032, 32'h0,       32'h12345678, 3, 0, 0);
      run1(1, 32'd1028, 32'h55556666, 32'h12345678, 3, 0, 2);
      chk("w1_mem2", mem1[2], 32'hA002);
      chk("w1_mem3", mem1[3], 32'hA003);

      repeat (3) @(posedge clk);
      chk("sb_empty", sb.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
